iomem_gpio: RTL and testbench
=============================

Name: iomem_gpio

Overview:
- Parametrised GPIO peripheral on the PicoSoC iomem bus; supersedes the single flat 32-bit gpio register.
- Adds per-bit output enable, atomic set/clear, synchronised inputs and per-bit edge interrupts.
- Decodes one 16 MB window of iomem (addr[31:24] == BASE_ADDR).
- Drives pad-side out/oe vectors and a level irq toward the CPU irq lines.

Parameters:
- BASE_ADDR, 8'h03, value matched against iomem_addr[31:24].
- WIDTH, 32, number of GPIO bits, 1..32.
- SYNC_STAGES, 2, input synchroniser depth, 2..4.

Ports:
- clk  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- iomem_valid  in  1  request valid
- iomem_ready  out  1  single-cycle completion pulse
- iomem_wstrb  in  4  byte write strobes; 0 = read
- iomem_addr  in  32  byte address
- iomem_wdata  in  32  write data
- iomem_rdata  out  32  read data, valid while iomem_ready is high
- gpio_out  out  WIDTH  output data
- gpio_oe  out  WIDTH  per-bit output enable
- gpio_in  in  WIDTH  asynchronous pad inputs
- irq  out  1  level interrupt, OR of (PEND & IEN)

Behaviour:
- Reset clears to 0:
  - outputs: iomem_ready, iomem_rdata, gpio_out, gpio_oe, irq
  - all registers and synchroniser flops
  - the settle counter
- Handshake:
  - When iomem_valid && !iomem_ready && addr[31:24]==BASE_ADDR, iomem_ready goes high for exactly one cycle on the next edge; otherwise it is 0.
  - Read data and write effects are registered on that same edge.
  - Back-to-back requests are therefore serviced every second cycle.
  - Requests outside the window are ignored; ready stays 0.
- Register map, selected by addr[4:2] (addr[23:5] ignored, aliased):
  - 0 OUT: R/W
  - 1 OE: R/W
  - 2 IN: RO, synchronised input
  - 3 IEN: R/W
  - 4 EDGE: R/W; 1 = rising, 0 = falling
  - 5 PEND: read returns pending bits; write-1-to-clear
  - 6 SET: WO; OUT |= wdata
  - 7 CLR: WO; OUT &= ~wdata
- Write and read rules:
  - Writes honour iomem_wstrb per byte. For SET, CLR and PEND, masked-off bytes are treated as 0.
  - Reads of SET and CLR return 0. Bits at or above WIDTH read 0 and ignore writes.
  - iomem_rdata holds its value between transactions.
- Input path:
  - gpio_in passes through a SYNC_STAGES flop chain, then one "prev" flop.
  - rise = sync & ~prev; fall = ~sync & prev.
  - event[i] = EDGE[i] ? rise[i] : fall[i].
- Settle counter:
  - Counts from 0 to SYNC_STAGES+1 after reset deassertion.
  - Events are suppressed until it saturates, so no spurious edge is captured from the reset value.
- PEND:
  - PEND[i] sets on event[i] regardless of IEN.
  - If a W1C of bit i and event[i] occur in the same cycle, set wins and PEND[i] stays 1.
- irq is registered: it is high one cycle after PEND & IEN becomes nonzero.
- Latency from a pad edge to PEND visible is SYNC_STAGES+1 cycles.
- Reset asserted mid-transaction:
  - iomem_ready and all state clear immediately.
  - The interrupted write has no effect.
  - The master re-issues the request.

Decomposition:
- Shared package gpio_pkg holds:
  - register offset constants REG_OUT..REG_CLR
  - SYNC_STAGES bounds
- One sub-module, gpio_sync_edge: per-vector synchroniser, prev flop and rise/fall outputs, parametrised by WIDTH and SYNC_STAGES.
- Bus decode, the register file and the settle counter stay in iomem_gpio.

Test Plan:
- Reset release, read all 8 offsets -> all return 0; irq=0; a request at addr 0x0400_0000 never gets iomem_ready.
- Write OUT=0x0000_00A5 with wstrb=4'b0001, then SET 0x100, then CLR 0x5 -> OUT reads 0x0000_01A0; gpio_out matches; each ready is exactly one cycle.
- WIDTH=8: write OUT=0xFFFF_FFFF -> reads 0x0000_00FF; byte write to OE with wstrb=4'b0010 -> OE unchanged.
- EDGE=0x1, IEN=0x1, drive gpio_in[0] 0->1 -> PEND[0]=1 at exactly SYNC_STAGES+1 cycles; irq high the next cycle; 1->0 sets nothing.
- Schedule W1C PEND=0x1 on the same cycle as a new rising event on bit 0 -> PEND[0] remains 1 and irq stays high.
- Hold gpio_in=0xFF through reset release with EDGE=0xFF -> PEND stays 0; assert resetn low during a pending write -> register unchanged after reset.

Source files
------------

// File: rtl/gpio_pkg.sv
// rtl/gpio_pkg.sv - register offsets, synchroniser bounds and byte-lane helper for iomem_gpio
package gpio_pkg;

  typedef enum logic [2:0] {
    REG_OUT  = 3'd0,
    REG_OE   = 3'd1,
    REG_IN   = 3'd2,
    REG_IEN  = 3'd3,
    REG_EDGE = 3'd4,
    REG_PEND = 3'd5,
    REG_SET  = 3'd6,
    REG_CLR  = 3'd7
  } gpio_reg_e;

  localparam int SYNC_STAGES_MIN = 2;
  localparam int SYNC_STAGES_MAX = 4;

  function automatic logic [31:0] byte_mask(input logic [3:0] wstrb);
    byte_mask = {{8{wstrb[3]}}, {8{wstrb[2]}}, {8{wstrb[1]}}, {8{wstrb[0]}}};
  endfunction

endpackage

// File: rtl/gpio_sync_edge.sv
// rtl/gpio_sync_edge.sv - input synchroniser chain with prev flop and rise/fall detection
module gpio_sync_edge #(
  parameter int WIDTH       = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] sync,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
);

  logic [WIDTH-1:0] stage_q [SYNC_STAGES];
  logic [WIDTH-1:0] stage_d [SYNC_STAGES];
  logic [WIDTH-1:0] prev_q;
  logic [WIDTH-1:0] prev_d;

  always_comb begin
    stage_d[0] = din;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      stage_d[i] = stage_q[i-1];
    end
    prev_d = stage_q[SYNC_STAGES-1];
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        stage_q[i] <= '0;
      end
      prev_q <= '0;
    end else begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        stage_q[i] <= stage_d[i];
      end
      prev_q <= prev_d;
    end
  end

  assign sync = stage_q[SYNC_STAGES-1];
  assign rise = sync & ~prev_q;
  assign fall = ~sync & prev_q;

endmodule

// File: rtl/iomem_gpio.sv
// rtl/iomem_gpio.sv - PicoSoC iomem GPIO: out/oe, atomic set/clear, synchronised inputs, edge irq
module iomem_gpio
  import gpio_pkg::*;
#(
  parameter logic [7:0] BASE_ADDR   = 8'h03,
  parameter int         WIDTH       = 32,
  parameter int         SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             iomem_valid,
  output logic             iomem_ready,
  input  logic [3:0]       iomem_wstrb,
  input  logic [31:0]      iomem_addr,
  input  logic [31:0]      iomem_wdata,
  output logic [31:0]      iomem_rdata,
  output logic [WIDTH-1:0] gpio_out,
  output logic [WIDTH-1:0] gpio_oe,
  input  logic [WIDTH-1:0] gpio_in,
  output logic             irq
);

  localparam int SYNC_EFF = (SYNC_STAGES < SYNC_STAGES_MIN) ? SYNC_STAGES_MIN :
                            (SYNC_STAGES > SYNC_STAGES_MAX) ? SYNC_STAGES_MAX : SYNC_STAGES;
  localparam logic [2:0] SETTLE_MAX = 3'(SYNC_EFF + 1);

  logic [WIDTH-1:0] out_q, out_d, oe_q, oe_d, ien_q, ien_d;
  logic [WIDTH-1:0] edge_sel_q, edge_sel_d, pend_q, pend_d;
  logic             ready_q, ready_d, irq_q, irq_d;
  logic [31:0]      rdata_q, rdata_d;
  logic [2:0]       cnt_q, cnt_d;

  logic [WIDTH-1:0] sync, rise, fall, evt, wmask, wval;
  logic [31:0]      bmask;
  logic             hit, wr_en, rd_en, settled;
  gpio_reg_e        sel;
  logic             unused_bits;

  function automatic logic [31:0] zext(input logic [WIDTH-1:0] v);
    zext = '0;
    zext[WIDTH-1:0] = v;
  endfunction

  gpio_sync_edge #(
    .WIDTH      (WIDTH),
    .SYNC_STAGES(SYNC_EFF)
  ) u_sync_edge (
    .clk   (clk),
    .resetn(resetn),
    .din   (gpio_in),
    .sync  (sync),
    .rise  (rise),
    .fall  (fall)
  );

  always_comb begin
    hit     = iomem_valid && !ready_q && (iomem_addr[31:24] == BASE_ADDR);
    sel     = gpio_reg_e'(iomem_addr[4:2]);
    wr_en   = hit && (iomem_wstrb != 4'b0000);
    rd_en   = hit && (iomem_wstrb == 4'b0000);
    bmask   = byte_mask(iomem_wstrb);
    wmask   = bmask[WIDTH-1:0];
    wval    = iomem_wdata[WIDTH-1:0] & wmask;
    // The chain and prev flop leave reset at 0; a pad already high would look like a rise.
    settled = (cnt_q == SETTLE_MAX);
    cnt_d   = settled ? cnt_q : cnt_q + 3'd1;
    evt     = settled ? ((edge_sel_q & rise) | (~edge_sel_q & fall)) : '0;

    ready_d    = hit;
    out_d      = out_q;
    oe_d       = oe_q;
    ien_d      = ien_q;
    edge_sel_d = edge_sel_q;
    pend_d     = pend_q;
    if (wr_en) begin
      case (sel)
        REG_OUT:  out_d      = (out_q & ~wmask) | wval;
        REG_OE:   oe_d       = (oe_q & ~wmask) | wval;
        REG_IEN:  ien_d      = (ien_q & ~wmask) | wval;
        REG_EDGE: edge_sel_d = (edge_sel_q & ~wmask) | wval;
        REG_PEND: pend_d     = pend_q & ~wval;
        REG_SET:  out_d      = out_q | wval;
        REG_CLR:  out_d      = out_q & ~wval;
        default:  ;
      endcase
    end
    // A fresh event outranks a simultaneous W1C.
    pend_d = pend_d | evt;
    irq_d  = |(pend_q & ien_q);

    rdata_d = rdata_q;
    if (rd_en) begin
      case (sel)
        REG_OUT:  rdata_d = zext(out_q);
        REG_OE:   rdata_d = zext(oe_q);
        REG_IN:   rdata_d = zext(sync);
        REG_IEN:  rdata_d = zext(ien_q);
        REG_EDGE: rdata_d = zext(edge_sel_q);
        REG_PEND: rdata_d = zext(pend_q);
        default:  rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      out_q      <= '0;
      oe_q       <= '0;
      ien_q      <= '0;
      edge_sel_q <= '0;
      pend_q     <= '0;
      ready_q    <= 1'b0;
      irq_q      <= 1'b0;
      rdata_q    <= '0;
      cnt_q      <= '0;
    end else begin
      out_q      <= out_d;
      oe_q       <= oe_d;
      ien_q      <= ien_d;
      edge_sel_q <= edge_sel_d;
      pend_q     <= pend_d;
      ready_q    <= ready_d;
      irq_q      <= irq_d;
      rdata_q    <= rdata_d;
      cnt_q      <= cnt_d;
    end
  end

  assign iomem_ready = ready_q;
  assign iomem_rdata = rdata_q;
  assign gpio_out    = out_q;
  assign gpio_oe     = oe_q;
  assign irq         = irq_q;
  assign unused_bits = ^{iomem_addr[23:5], iomem_addr[1:0], iomem_wdata, bmask};

endmodule

// File: tb/tb_iomem_gpio.sv
// tb/tb_iomem_gpio.sv - self-checking bench for iomem_gpio with table vectors and a random model run
module tb_iomem_gpio;
  import gpio_pkg::*;

  localparam int S = 2;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        valid = 1'b0;
  logic        valid8 = 1'b0;
  logic [3:0]  wstrb = 4'h0;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic [31:0] gpio_in = 32'h0;
  logic [7:0]  gpio_in8 = 8'h0;
  logic        ready, ready8, irq, irq8;
  logic [31:0] rdata, rdata8, gpio_out, gpio_oe;
  logic [7:0]  out8, oe8;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] m_out, m_oe, m_ien, m_edge, m_pend, last_evt, pre_sync, pre_pend;
  logic        m_irq;
  logic [31:0] h [S+1];
  int          ncyc;

  typedef struct {
    logic        we;
    logic [2:0]  sel;
    logic [3:0]  strb;
    logic [31:0] data;
    logic [31:0] exp;
  } vec_t;
  vec_t tbl [14];

  iomem_gpio dut (
    .clk(clk), .resetn(resetn), .iomem_valid(valid), .iomem_ready(ready),
    .iomem_wstrb(wstrb), .iomem_addr(addr), .iomem_wdata(wdata), .iomem_rdata(rdata),
    .gpio_out(gpio_out), .gpio_oe(gpio_oe), .gpio_in(gpio_in), .irq(irq)
  );

  iomem_gpio #(.WIDTH(8)) dut8 (
    .clk(clk), .resetn(resetn), .iomem_valid(valid8), .iomem_ready(ready8),
    .iomem_wstrb(wstrb), .iomem_addr(addr), .iomem_wdata(wdata), .iomem_rdata(rdata8),
    .gpio_out(out8), .gpio_oe(oe8), .gpio_in(gpio_in8), .irq(irq8)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_out = 0; m_oe = 0; m_ien = 0; m_edge = 0; m_pend = 0; m_irq = 0;
    last_evt = 0; pre_sync = 0; pre_pend = 0; ncyc = 0;
    for (int i = 0; i <= S; i++) h[i] = 0;
  endtask

  // Pad values walk through a delay line; the oldest two samples are the observed level and its predecessor.
  task automatic model_edge();
    logic [31:0] lvl, prv, evt;
    lvl = h[S-1];
    prv = h[S];
    evt = (m_edge & lvl & ~prv) | (~m_edge & ~lvl & prv);
    if (ncyc < S + 1) begin
      evt = 0;
      ncyc++;
    end
    pre_sync = lvl;
    pre_pend = m_pend;
    m_irq    = |(m_pend & m_ien);
    m_pend   = m_pend | evt;
    last_evt = evt;
    for (int i = S; i > 0; i--) h[i] = h[i-1];
    h[0] = gpio_in;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    model_reset();
    resetn = 1'b1;
  endtask

  task automatic bus(input logic we, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                     output logic [31:0] rd, output logic [31:0] m_rd, output logic got);
    logic [31:0] m;
    addr = a; wdata = d; wstrb = we ? s : 4'h0; valid = 1'b1;
    got = 1'b0; rd = 32'h0; m_rd = 32'h0;
    for (int i = 0; i < 4; i++) begin
      if (!got) begin
        tick();
        if (ready) begin
          got = 1'b1;
          rd = rdata;
        end
      end
    end
    if (got) begin
      case (a[4:2])
        3'd0: m_rd = m_out;
        3'd1: m_rd = m_oe;
        3'd2: m_rd = pre_sync;
        3'd3: m_rd = m_ien;
        3'd4: m_rd = m_edge;
        3'd5: m_rd = pre_pend;
        default: m_rd = 0;
      endcase
      if (we) begin
        m = byte_mask(s);
        case (a[4:2])
          3'd0: m_out  = (m_out & ~m) | (d & m);
          3'd1: m_oe   = (m_oe & ~m) | (d & m);
          3'd3: m_ien  = (m_ien & ~m) | (d & m);
          3'd4: m_edge = (m_edge & ~m) | (d & m);
          3'd5: m_pend = (m_pend & ~(d & m)) | last_evt;
          3'd6: m_out  = m_out | (d & m);
          3'd7: m_out  = m_out & ~(d & m);
          default: ;
        endcase
      end
      tick();
      chk("ready_one_cycle", {31'b0, ready}, 32'h0);
    end
    valid = 1'b0;
  endtask

  task automatic reg_op(input string name, input logic we, input logic [2:0] sel,
                        input logic [31:0] d, input logic [3:0] s, output logic [31:0] rd);
    logic [31:0] m_rd;
    logic        got;
    bus(we, {8'h03, 19'h0, sel, 2'b00}, d, s, rd, m_rd, got);
    chk({name, "_ready"}, {31'b0, got}, 32'h1);
    if (!we) chk({name, "_model"}, rd, m_rd);
  endtask

  task automatic bus8(input logic we, input logic [2:0] sel, input logic [31:0] d, input logic [3:0] s,
                      output logic [31:0] rd);
    logic got;
    addr = {8'h03, 19'h0, sel, 2'b00}; wdata = d; wstrb = we ? s : 4'h0; valid8 = 1'b1;
    rd = 32'hDEAD_BEEF; got = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (!got) begin
        tick();
        if (ready8) begin
          got = 1'b1;
          rd = rdata8;
        end
      end
    end
    tick();
    valid8 = 1'b0;
  endtask

  initial begin
    logic [31:0] rd, m_rd, a, d;
    logic        got, we;
    logic [3:0]  s;
    logic [2:0]  sel;
    logic [7:0]  top;
    bit          inwin;

    model_reset();
    do_reset();

    for (int i = 0; i < 8; i++) begin
      reg_op("reset_read", 1'b0, 3'(i), 32'h0, 4'h0, rd);
      chk("reset_value", rd, 32'h0);
    end
    chk("reset_irq", {31'b0, irq}, 32'h0);
    chk("reset_out", gpio_out, 32'h0);
    bus(1'b0, 32'h0400_0000, 32'h0, 4'h0, rd, m_rd, got);
    chk("outside_window_ready", {31'b0, got}, 32'h0);

    tbl[0]  = '{1'b1, REG_OUT,  4'b0001, 32'h0000_00A5, 32'h0};
    tbl[1]  = '{1'b1, REG_SET,  4'b1111, 32'h0000_0100, 32'h0};
    tbl[2]  = '{1'b1, REG_CLR,  4'b1111, 32'h0000_0005, 32'h0};
    tbl[3]  = '{1'b0, REG_OUT,  4'b0000, 32'h0,         32'h0000_01A0};
    tbl[4]  = '{1'b1, REG_OUT,  4'b0110, 32'h1234_5678, 32'h0};
    tbl[5]  = '{1'b0, REG_OUT,  4'b0000, 32'h0,         32'h0034_56A0};
    tbl[6]  = '{1'b1, REG_SET,  4'b0011, 32'hFFFF_0000, 32'h0};
    tbl[7]  = '{1'b0, REG_OUT,  4'b0000, 32'h0,         32'h0034_56A0};
    tbl[8]  = '{1'b0, REG_SET,  4'b0000, 32'h0,         32'h0};
    tbl[9]  = '{1'b0, REG_CLR,  4'b0000, 32'h0,         32'h0};
    tbl[10] = '{1'b1, REG_OE,   4'b1111, 32'h0F0F_00FF, 32'h0};
    tbl[11] = '{1'b0, REG_OE,   4'b0000, 32'h0,         32'h0F0F_00FF};
    tbl[12] = '{1'b1, REG_CLR,  4'b0100, 32'h00FF_00FF, 32'h0};
    tbl[13] = '{1'b0, REG_OUT,  4'b0000, 32'h0,         32'h0000_56A0};
    for (int i = 0; i < 14; i++) begin
      reg_op("table", tbl[i].we, tbl[i].sel, tbl[i].data, tbl[i].strb, rd);
      if (!tbl[i].we) chk($sformatf("table_rdata_%0d", i), rd, tbl[i].exp);
      chk("table_gpio_out", gpio_out, m_out);
    end
    chk("table_gpio_oe", gpio_oe, 32'h0F0F_00FF);

    bus8(1'b1, REG_OUT, 32'hFFFF_FFFF, 4'b1111, rd);
    bus8(1'b0, REG_OUT, 32'h0, 4'h0, rd);
    chk("w8_out_read", rd, 32'h0000_00FF);
    bus8(1'b1, REG_OE, 32'h0000_005A, 4'b1111, rd);
    bus8(1'b1, REG_OE, 32'hFFFF_FFFF, 4'b0010, rd);
    bus8(1'b0, REG_OE, 32'h0, 4'h0, rd);
    chk("w8_oe_byte1_ignored", rd, 32'h0000_005A);
    chk("w8_oe_pins", {24'h0, oe8}, 32'h0000_005A);

    reg_op("edge_cfg", 1'b1, REG_EDGE, 32'h1, 4'hF, rd);
    reg_op("ien_cfg", 1'b1, REG_IEN, 32'h1, 4'hF, rd);
    gpio_in[0] = 1'b1;
    for (int k = 1; k <= S + 2; k++) begin
      tick();
      chk($sformatf("rise_irq_at_%0d", k), {31'b0, irq}, (k == S + 2) ? 32'h1 : 32'h0);
    end
    reg_op("pend_after_rise", 1'b0, REG_PEND, 32'h0, 4'h0, rd);
    chk("pend_rise", rd, 32'h1);
    reg_op("pend_w1c", 1'b1, REG_PEND, 32'h1, 4'hF, rd);
    gpio_in[0] = 1'b0;
    repeat (S + 3) tick();
    reg_op("pend_after_fall", 1'b0, REG_PEND, 32'h0, 4'h0, rd);
    chk("pend_fall_ignored", rd, 32'h0);
    chk("irq_after_fall", {31'b0, irq}, 32'h0);

    gpio_in[0] = 1'b1;
    repeat (S + 3) tick();
    chk("irq_before_collision", {31'b0, irq}, 32'h1);
    gpio_in[0] = 1'b0;
    repeat (S + 3) tick();
    gpio_in[0] = 1'b1;
    repeat (S) tick();
    reg_op("collide_w1c", 1'b1, REG_PEND, 32'h1, 4'hF, rd);
    chk("irq_collision", {31'b0, irq}, 32'h1);
    reg_op("collide_read", 1'b0, REG_PEND, 32'h0, 4'h0, rd);
    chk("pend_collision_set_wins", rd, 32'h1);
    chk("irq_after_collision", {31'b0, irq}, 32'h1);

    for (int k = 0; k < 200; k++) begin
      if ($urandom_range(0, 3) == 0) gpio_in = $urandom;
      sel   = 3'($urandom_range(0, 7));
      we    = 1'($urandom_range(0, 1));
      s     = 4'($urandom_range(1, 15));
      d     = $urandom;
      inwin = ($urandom_range(0, 9) != 0);
      top   = inwin ? 8'h03 : 8'($urandom_range(4, 255));
      a     = {top, 19'($urandom), sel, 2'($urandom)};
      bus(we, a, d, s, rd, m_rd, got);
      if (inwin) begin
        chk("rand_ready", {31'b0, got}, 32'h1);
        if (!we) chk($sformatf("rand_read_reg%0d", sel), rd, m_rd);
      end else begin
        chk("rand_outside_ready", {31'b0, got}, 32'h0);
      end
      chk("rand_gpio_out", gpio_out, m_out);
      chk("rand_gpio_oe", gpio_oe, m_oe);
      chk("rand_irq", {31'b0, irq}, {31'b0, m_irq});
    end

    gpio_in = 32'h0000_00FF;
    do_reset();
    reg_op("settle_edge", 1'b1, REG_EDGE, 32'hFF, 4'hF, rd);
    reg_op("settle_ien", 1'b1, REG_IEN, 32'hFF, 4'hF, rd);
    repeat (S + 4) tick();
    reg_op("settle_pend", 1'b0, REG_PEND, 32'h0, 4'h0, rd);
    chk("settle_no_spurious", rd, 32'h0);
    chk("settle_irq", {31'b0, irq}, 32'h0);

    reg_op("pre_reset_out", 1'b1, REG_OUT, 32'h55, 4'hF, rd);
    chk("pre_reset_pins", gpio_out, 32'h55);
    addr = {8'h03, 19'h0, 3'(REG_OUT), 2'b00}; wdata = 32'hAA; wstrb = 4'hF; valid = 1'b1;
    resetn = 1'b0;
    @(posedge clk);
    #1;
    chk("midreset_ready", {31'b0, ready}, 32'h0);
    chk("midreset_out", gpio_out, 32'h0);
    valid = 1'b0;
    @(posedge clk);
    #1;
    model_reset();
    resetn = 1'b1;
    reg_op("post_reset_out", 1'b0, REG_OUT, 32'h0, 4'h0, rd);
    chk("interrupted_write_dropped", rd, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
